// File: rtl/pipe_id_ex_if.sv
// Decode-to-execute bus: decode-stage fields (_d) in, registered execute-stage fields (_e) out.
interface pipe_id_ex_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int ALU_W = 3
);
  logic [XLEN-1:0]  rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus_4_d;
  logic [REG_W-1:0] rs1_d, rs2_d, rd_d;
  logic             reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, valid_d;
  logic [1:0]       result_src_d;
  logic [ALU_W-1:0] alu_control_d;

  logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus_4_e;
  logic [REG_W-1:0] rs1_e, rs2_e, rd_e;
  logic             reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e;
  logic [1:0]       result_src_e;
  logic [ALU_W-1:0] alu_control_e;

  modport master (
    output rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus_4_d, rs1_d, rs2_d, rd_d,
           reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, valid_d,
           result_src_d, alu_control_d,
    input  rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus_4_e, rs1_e, rs2_e, rd_e,
           reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e,
           result_src_e, alu_control_e
  );

  modport slave (
    input  rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus_4_d, rs1_d, rs2_d, rd_d,
           reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, valid_d,
           result_src_d, alu_control_d,
    output rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus_4_e, rs1_e, rs2_e, rd_e,
           reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e,
           result_src_e, alu_control_e
  );
endinterface

// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register with stall hold, flush bubble, squashing of side-effecting
// controls for invalid instructions, and saturating bubble/stall performance counters.
module pipe_id_ex #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int ALU_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  pipe_id_ex_if.slave      bus,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm_ext;
    logic [XLEN-1:0]  pc_plus_4;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic             alu_src;
    logic [1:0]       result_src;
    logic [ALU_W-1:0] alu_control;
    logic             valid;
  } id_ex_t;

  id_ex_t           ex_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Pipeline register and counters; priority reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r         <= '0;
      bubble_cnt_r <= '0;
      stall_cnt_r  <= '0;
    end else if (flush_e) begin
      ex_r         <= '0;
      bubble_cnt_r <= sat_inc(bubble_cnt_r);
    end else if (stall_e) begin
      stall_cnt_r  <= sat_inc(stall_cnt_r);
    end else begin
      // Side-effecting controls are only carried by a valid instruction
      ex_r <= '{rd1:         bus.rd1_d,
                rd2:         bus.rd2_d,
                pc:          bus.pc_d,
                imm_ext:     bus.imm_ext_d,
                pc_plus_4:   bus.pc_plus_4_d,
                rs1:         bus.rs1_d,
                rs2:         bus.rs2_d,
                rd:          bus.rd_d,
                reg_write:   bus.reg_write_d & bus.valid_d,
                mem_write:   bus.mem_write_d & bus.valid_d,
                jump:        bus.jump_d      & bus.valid_d,
                branch:      bus.branch_d    & bus.valid_d,
                alu_src:     bus.alu_src_d,
                result_src:  bus.result_src_d,
                alu_control: bus.alu_control_d,
                valid:       bus.valid_d};
    end
  end

  assign bus.rd1_e         = ex_r.rd1;
  assign bus.rd2_e         = ex_r.rd2;
  assign bus.pc_e          = ex_r.pc;
  assign bus.imm_ext_e     = ex_r.imm_ext;
  assign bus.pc_plus_4_e   = ex_r.pc_plus_4;
  assign bus.rs1_e         = ex_r.rs1;
  assign bus.rs2_e         = ex_r.rs2;
  assign bus.rd_e          = ex_r.rd;
  assign bus.reg_write_e   = ex_r.reg_write;
  assign bus.mem_write_e   = ex_r.mem_write;
  assign bus.jump_e        = ex_r.jump;
  assign bus.branch_e      = ex_r.branch;
  assign bus.alu_src_e     = ex_r.alu_src;
  assign bus.result_src_e  = ex_r.result_src;
  assign bus.alu_control_e = ex_r.alu_control;
  assign bus.valid_e       = ex_r.valid;
  assign bubble_cnt        = bubble_cnt_r;
  assign stall_cnt         = stall_cnt_r;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Randomized scoreboard bench for pipe_id_ex (CNT_W=4 so counter saturation is reached quickly).
module tb_pipe_id_ex;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic        v;
  } flds_t;

  typedef struct packed {
    flds_t      f;
    logic [3:0] bc;
    logic [3:0] sc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, stall_e, flush_e;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;
  int               checks = 0;
  int               errors = 0;
  exp_t             mdl = '0;
  exp_t             scb[$];

  pipe_id_ex_if #(.XLEN(32), .REG_W(5), .ALU_W(3)) bus ();

  pipe_id_ex #(.XLEN(32), .REG_W(5), .ALU_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .bus(bus), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] sat(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Reference: one rising edge applied to the model, expectation queued for the monitor
  task automatic cycle();
    exp_t n = mdl;
    if (reset) n = '0;
    else if (flush_e) begin
      n.f  = '0;
      n.bc = sat(mdl.bc);
    end else if (stall_e) n.sc = sat(mdl.sc);
    else begin
      n.f = '{rd1: bus.rd1_d, rd2: bus.rd2_d, pc: bus.pc_d, imm: bus.imm_ext_d,
              pc4: bus.pc_plus_4_d, rs1: bus.rs1_d, rs2: bus.rs2_d, rd: bus.rd_d,
              rw: bus.reg_write_d && bus.valid_d, mw: bus.mem_write_d && bus.valid_d,
              j: bus.jump_d && bus.valid_d, b: bus.branch_d && bus.valid_d,
              as: bus.alu_src_d, rs: bus.result_src_d, alu: bus.alu_control_d,
              v: bus.valid_d};
    end
    @(posedge clk);
    mdl = n;
    scb.push_back(n);
    #1;
  endtask

  task automatic rand_bus();
    logic [31:0] r;
    bus.rd1_d = $urandom(); bus.rd2_d = $urandom(); bus.pc_d = $urandom();
    bus.imm_ext_d = $urandom(); bus.pc_plus_4_d = $urandom();
    r = $urandom();
    bus.rs1_d = r[4:0]; bus.rs2_d = r[9:5]; bus.rd_d = r[14:10];
    bus.reg_write_d = r[15]; bus.mem_write_d = r[16]; bus.jump_d = r[17];
    bus.branch_d = r[18]; bus.alu_src_d = r[19]; bus.result_src_d = r[21:20];
    bus.alu_control_d = r[24:22]; bus.valid_d = r[25];
  endtask

  // Monitor: each negedge after an edge, pop the expectation and compare
  initial begin
    exp_t  e;
    flds_t a;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        a = '{rd1: bus.rd1_e, rd2: bus.rd2_e, pc: bus.pc_e, imm: bus.imm_ext_e,
              pc4: bus.pc_plus_4_e, rs1: bus.rs1_e, rs2: bus.rs2_e, rd: bus.rd_e,
              rw: bus.reg_write_e, mw: bus.mem_write_e, j: bus.jump_e, b: bus.branch_e,
              as: bus.alu_src_e, rs: bus.result_src_e, alu: bus.alu_control_e,
              v: bus.valid_e};
        chk("fields", 256'(a), 256'(e.f));
        chk("valid_e", 256'(bus.valid_e), 256'(e.f.v));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(e.bc));
        chk("stall_cnt", 256'(stall_cnt), 256'(e.sc));
      end
    end
  end

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rand_bus();
    #1;
    cycle(); cycle();
    chk("reset_pc", 256'(bus.pc_e), 256'(32'h0));
    chk("reset_valid", 256'(bus.valid_e), 256'(1'b0));
    reset = 1'b0;

    // Basic load
    bus.valid_d = 1'b1; bus.pc_d = 32'h10; bus.rd1_d = 32'hDEAD_BEEF;
    bus.reg_write_d = 1'b1; bus.alu_control_d = 3'b010;
    cycle();
    chk("t1_pc", 256'(bus.pc_e), 256'(32'h10));
    chk("t1_rd1", 256'(bus.rd1_e), 256'(32'hDEAD_BEEF));
    chk("t1_rw", 256'(bus.reg_write_e), 256'(1'b1));
    chk("t1_alu", 256'(bus.alu_control_e), 256'(3'b010));
    chk("t1_valid", 256'(bus.valid_e), 256'(1'b1));

    // Stall for three cycles
    bus.pc_d = 32'h20; cycle();
    stall_e = 1'b1; bus.pc_d = 32'h24;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_pc", 256'(bus.pc_e), 256'(32'h20));
    end
    chk("t2_stall_cnt", 256'(stall_cnt), 256'(4'd3));
    stall_e = 1'b0; cycle();
    chk("t2_release_pc", 256'(bus.pc_e), 256'(32'h24));

    // Flush wins over stall
    bus.mem_write_d = 1'b1; cycle();
    chk("t3_mw_loaded", 256'(bus.mem_write_e), 256'(1'b1));
    flush_e = 1'b1; stall_e = 1'b1; cycle();
    chk("t3_mw", 256'(bus.mem_write_e), 256'(1'b0));
    chk("t3_pc", 256'(bus.pc_e), 256'(32'h0));
    chk("t3_valid", 256'(bus.valid_e), 256'(1'b0));
    chk("t3_bubble", 256'(bubble_cnt), 256'(4'd1));
    chk("t3_stall", 256'(stall_cnt), 256'(4'd3));
    flush_e = 1'b0; stall_e = 1'b0;

    // Squash of invalid instruction
    bus.valid_d = 1'b0; bus.reg_write_d = 1'b1; bus.mem_write_d = 1'b1;
    bus.branch_d = 1'b1; bus.jump_d = 1'b1; bus.rd_d = 5'd7;
    cycle();
    chk("t4_ctrl", 256'({bus.reg_write_e, bus.mem_write_e, bus.branch_e, bus.jump_e}), 256'(4'b0));
    chk("t4_rd", 256'(bus.rd_e), 256'(5'd7));
    chk("t4_valid", 256'(bus.valid_e), 256'(1'b0));

    // Reset pulse between edges has no effect
    bus.valid_d = 1'b1; cycle();
    #2 reset = 1'b1; #1 reset = 1'b0;
    stall_e = 1'b1; cycle();
    chk("t7_glitch_valid", 256'(bus.valid_e), 256'(1'b1));

    // Bubble counter saturation
    stall_e = 1'b0; flush_e = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("t5_bubble_sat", 256'(bubble_cnt), 256'(4'd15));
    flush_e = 1'b0;

    // Reset during stall with nonzero counters
    stall_e = 1'b1; cycle();
    reset = 1'b1; cycle();
    chk("t6_bubble", 256'(bubble_cnt), 256'(4'd0));
    chk("t6_stall", 256'(stall_cnt), 256'(4'd0));
    chk("t6_valid", 256'(bus.valid_e), 256'(1'b0));
    reset = 1'b0; stall_e = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_bus();
      reset   = ($urandom_range(99) < 2);
      flush_e = ($urandom_range(99) < 15);
      stall_e = ($urandom_range(99) < 30);
      cycle();
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 256'(scb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
